// File: rtl/bsg_dff_negedge_pipe_reset_en_pkg.sv
// Shared helpers for the falling-edge stallable delay line.
package bsg_dff_negedge_pipe_reset_en_pkg;

  // Never returns 0, so a derived width stays legal for degenerate sizes.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_dff_negedge_reset_en_val.sv
// Single falling-edge register with load enable and async active-high reset to
// a programmable value.
module bsg_dff_negedge_reset_en_val #(
  parameter int                 width_p     = 1,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = data_i;
  end

  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) data_q <= reset_val_p;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_dff_negedge_pipe_reset_en.sv
// els_p-stage falling-edge delay line with global enable, per-stage valids and
// an occupancy counter. Optional macro: BSG_DFF_NEGEDGE_PIPE_GATE_INVALID_EN.
module bsg_dff_negedge_pipe_reset_en
  import bsg_dff_negedge_pipe_reset_en_pkg::*;
#(
  parameter int                 width_p     = 1,
  parameter int                 els_p       = 1,
  parameter logic [width_p-1:0] reset_val_p = '0,
  parameter int                 lg_els_lp   = safe_clog2(els_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic                 v_i,
  input  logic [width_p-1:0]   data_i,
  output logic                 v_o,
  output logic [width_p-1:0]   data_o,
  output logic [lg_els_lp-1:0] count_o
);

  if (els_p < 1) begin : g_bad_els
    $error("bsg_dff_negedge_pipe_reset_en: els_p must be >= 1");
  end

  logic [els_p-1:0]   v_q;
  logic [width_p-1:0] data_q [els_p];

  for (genvar k = 0; k < els_p; k++) begin : g_stage
    logic               v_in;
    logic [width_p-1:0] d_in;
    logic               d_en;

    if (k == 0) begin : g_head
      assign v_in = v_i;
      assign d_in = data_i;
    end else begin : g_body
      assign v_in = v_q[k-1];
      assign d_in = data_q[k-1];
    end

`ifdef BSG_DFF_NEGEDGE_PIPE_GATE_INVALID_EN
    // Bubbles leave the data register untouched to save toggling.
    assign d_en = en_i & v_in;
`else
    assign d_en = en_i;
`endif

    bsg_dff_negedge_reset_en_val #(
      .width_p    (1),
      .reset_val_p(1'b0)
    ) u_v (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .en_i   (en_i),
      .data_i (v_in),
      .data_o (v_q[k])
    );

    bsg_dff_negedge_reset_en_val #(
      .width_p    (width_p),
      .reset_val_p(reset_val_p)
    ) u_d (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .en_i   (d_en),
      .data_i (d_in),
      .data_o (data_q[k])
    );
  end

  logic                 v_last;
  logic [lg_els_lp-1:0] count_q, count_d;

  assign v_last = v_q[els_p-1];

  // Entry and exit on the same edge cancel, so the count tracks popcount(v_q).
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (v_i && !v_last)      count_d = count_q + lg_els_lp'(1);
      else if (!v_i && v_last) count_d = count_q - lg_els_lp'(1);
    end
  end

  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign v_o     = v_last;
  assign count_o = count_q;

`ifdef BSG_DFF_NEGEDGE_PIPE_GATE_INVALID_EN
  assign data_o = v_last ? data_q[els_p-1] : reset_val_p;
`else
  assign data_o = data_q[els_p-1];
`endif

endmodule

// File: tb/tb_bsg_dff_negedge_pipe_reset_en.sv
// Directed bench for the falling-edge delay line: width 8, three stages, reset value A5.
module tb_bsg_dff_negedge_pipe_reset_en;

  localparam int         W   = 8;
  localparam int         N   = 3;
  localparam logic [7:0] RV  = 8'hA5;
  localparam int         CW  = 2;

  logic          clk_i = 1'b1;
  logic          reset_i = 1'b0;
  logic          en_i = 1'b0;
  logic          v_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic [CW-1:0] count_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  bsg_dff_negedge_pipe_reset_en #(
    .width_p    (W),
    .els_p      (N),
    .reset_val_p(RV)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (en_i),
    .v_i    (v_i),
    .data_i (data_i),
    .v_o    (v_o),
    .data_o (data_o),
    .count_o(count_o)
  );

  typedef struct {
    logic       en;
    logic       v;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] ec;
  } vec_t;

  // Raw last-stage data is what the ungated build shows; the gated build masks bubbles.
  function automatic logic [7:0] exp_data(input logic ev, input logic [7:0] raw);
`ifdef BSG_DFF_NEGEDGE_PIPE_GATE_INVALID_EN
    return ev ? raw : RV;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string name, input logic ev, input logic [7:0] ed,
                       input logic [1:0] ec);
    total++;
    if (v_o !== ev) begin
      bad++;
      $display("FAIL %s v_o: got %b want %b", name, v_o, ev);
    end
    total++;
    if (data_o !== ed) begin
      bad++;
      $display("FAIL %s data_o: got %h want %h", name, data_o, ed);
    end
    total++;
    if (count_o !== ec) begin
      bad++;
      $display("FAIL %s count_o: got %0d want %0d", name, count_o, ec);
    end
  endtask

  task automatic apply(input string name, input logic en, input logic v, input logic [7:0] d,
                       input logic ev, input logic [7:0] raw, input logic [1:0] ec);
    en_i   = en;
    v_i    = v;
    data_i = d;
    @(negedge clk_i);
    #1;
    check(name, ev, exp_data(ev, raw), ec);
  endtask

  vec_t vecs [17];

  initial begin
    // latency: one item, then bubbles
    vecs[0]  = '{1, 1, 8'h11, 0, 8'hA5, 1};
    vecs[1]  = '{1, 0, 8'h00, 0, 8'hA5, 1};
    vecs[2]  = '{1, 0, 8'h00, 1, 8'h11, 1};
    vecs[3]  = '{1, 0, 8'h00, 0, 8'h00, 0};
    // stall two edges while the item sits in stage 1
    vecs[4]  = '{1, 1, 8'h22, 0, 8'h00, 1};
    vecs[5]  = '{1, 0, 8'h00, 0, 8'h00, 1};
    vecs[6]  = '{0, 1, 8'h33, 0, 8'h00, 1};
    vecs[7]  = '{0, 1, 8'h44, 0, 8'h00, 1};
    vecs[8]  = '{1, 0, 8'h00, 1, 8'h22, 1};
    vecs[9]  = '{1, 0, 8'h55, 0, 8'h00, 0};
    // continuous stream: fill, saturate, stall while full
    vecs[10] = '{1, 1, 8'h01, 0, 8'h00, 1};
    vecs[11] = '{1, 1, 8'h02, 0, 8'h55, 2};
    vecs[12] = '{1, 1, 8'h03, 1, 8'h01, 3};
    vecs[13] = '{1, 1, 8'h04, 1, 8'h02, 3};
    vecs[14] = '{1, 1, 8'h05, 1, 8'h03, 3};
    vecs[15] = '{0, 0, 8'h99, 1, 8'h03, 3};
    vecs[16] = '{1, 1, 8'h06, 1, 8'h04, 3};

    // reset asserted while clk is high, before any falling edge
    #2;
    reset_i = 1'b1;
    #1;
    check("reset_async", 1'b0, RV, 2'd0);
    @(negedge clk_i);
    #1;
    check("reset_hold", 1'b0, RV, 2'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    for (int i = 0; i < 17; i++)
      apply($sformatf("vec%0d", i), vecs[i].en, vecs[i].v, vecs[i].d,
            vecs[i].ev, vecs[i].ed, vecs[i].ec);

    // reset pulse with a full pipeline, between falling edges
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    #1;
    check("midreset_async", 1'b0, RV, 2'd0);
    @(negedge clk_i);
    #1;
    check("midreset_hold", 1'b0, RV, 2'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    apply("post_reset_e1", 1, 1, 8'h77, 0, RV,    1);
    apply("post_reset_e2", 1, 0, 8'hFF, 0, RV,    1);
    apply("post_reset_e3", 1, 0, 8'hFF, 1, 8'h77, 1);
    // bubbles carrying FF: ungated build exposes FF, gated build shows reset value
    apply("gate_invalid_e4", 1, 0, 8'hFF, 0, 8'hFF, 0);
    apply("gate_invalid_e5", 1, 0, 8'hFF, 0, 8'hFF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
